// File: rtl/pipe_pkg.sv
// Shared pipeline-tracking types: register-index width, action/mode codes and
// the per-slot record carried through EX, MEM and WB.
package pipe_pkg;

  localparam int unsigned REG_W  = 7;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RUN      = 2'd0,
    MODE_LU_STALL = 2'd1,
    MODE_FREEZE   = 2'd2
  } mode_e;

  // One pipeline slot: tracked destination (0 = none) and load flag.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             is_load;
  } slot_t;

endpackage

// File: rtl/rd_pipe_tracker_if.sv
// Decode-side inputs and forwarding-side outputs of the destination tracker.
// master = decode/memory control side, slave = the tracker itself.
interface rd_pipe_tracker_if #(
  parameter int unsigned REG_W = pipe_pkg::REG_W,
  parameter int unsigned CNT_W = 16
);

  logic             id_valid;
  logic [REG_W-1:0] rs1_d;
  logic [REG_W-1:0] rs2_d;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_rd_we;
  logic             id_is_load;
  logic             flush_ex;
  logic             mem_busy;

  logic [REG_W-1:0] rd_EX;
  logic [REG_W-1:0] rd_MEM;
  logic [REG_W-1:0] rd_WB;
  logic             ex_is_load;
  logic             stall_id;
  logic [1:0]       mode;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, rs1_d, rs2_d, id_use_rs1, id_use_rs2,
           id_rd, id_rd_we, id_is_load, flush_ex, mem_busy,
    input  rd_EX, rd_MEM, rd_WB, ex_is_load, stall_id, mode, stall_cycles
  );

  modport slave (
    input  id_valid, rs1_d, rs2_d, id_use_rs1, id_use_rs2,
           id_rd, id_rd_we, id_is_load, flush_ex, mem_busy,
    output rd_EX, rd_MEM, rd_WB, ex_is_load, stall_id, mode, stall_cycles
  );

endinterface

// File: rtl/rd_pipe_tracker_hazard_detect.sv
// Combinational load-use compare: a load in EX whose destination is read by
// the instruction currently in decode.
module hazard_detect #(
  parameter int unsigned REG_W = 7
) (
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             id_valid,
  input  logic             id_use_rs1,
  input  logic [REG_W-1:0] rs1_d,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] rs2_d,
  output logic             load_use_c
);

  logic hit_rs1;
  logic hit_rs2;

  always_comb begin
    hit_rs1    = id_use_rs1 && (rs1_d == rd_ex);
    hit_rs2    = id_use_rs2 && (rs2_d == rd_ex);
    load_use_c = ex_is_load && id_valid && (hit_rs1 || hit_rs2);
  end

endmodule

// File: rtl/rd_pipe_tracker.sv
// Tracks destination registers through EX/MEM/WB for the forwarding unit,
// raises load-use stalls, freezes on busy memory and counts stall cycles.
module rd_pipe_tracker #(
  parameter int unsigned REG_W = pipe_pkg::REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  rd_pipe_tracker_if.slave   bus
);

  import pipe_pkg::*;

  localparam int unsigned SLOT_RD_W = pipe_pkg::REG_W;

  slot_t            ex_q,   ex_d;
  slot_t            mem_q,  mem_d;
  slot_t            wb_q,   wb_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  slot_t            entry;
  logic             load_use_c;
  logic             stall_id_c;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_is_load (ex_q.is_load),
    .rd_ex      (REG_W'(ex_q.rd)),
    .id_valid   (bus.id_valid),
    .id_use_rs1 (bus.id_use_rs1),
    .rs1_d      (bus.rs1_d),
    .id_use_rs2 (bus.id_use_rs2),
    .rs2_d      (bus.rs2_d),
    .load_use_c (load_use_c)
  );

  // Priority action encoder: FREEZE > FLUSH > LU_STALL > RUN.
  always_comb begin
    entry      = '0;
    ex_d       = ex_q;
    mem_d      = mem_q;
    wb_d       = wb_q;
    mode_d     = MODE_RUN;
    stall_id_c = 1'b0;

    if (bus.id_valid && bus.id_rd_we && (bus.id_rd != '0)) begin
      entry.rd      = SLOT_RD_W'(bus.id_rd);
      entry.is_load = bus.id_is_load;
    end

    if (bus.mem_busy) begin
      stall_id_c = 1'b1;
      mode_d     = MODE_FREEZE;
    end else begin
      ex_d  = '0;
      mem_d = ex_q;
      wb_d  = mem_q;
      if (!bus.flush_ex) begin
        if (load_use_c) begin
          stall_id_c = 1'b1;
          mode_d     = MODE_LU_STALL;
        end else begin
          ex_d = entry;
        end
      end
    end

    cnt_d = (stall_id_c && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      mode_q <= MODE_RUN;
      cnt_q  <= '0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.rd_EX        = REG_W'(ex_q.rd);
  assign bus.rd_MEM       = REG_W'(mem_q.rd);
  assign bus.rd_WB        = REG_W'(wb_q.rd);
  assign bus.ex_is_load   = ex_q.is_load;
  assign bus.mode         = mode_q;
  assign bus.stall_cycles = cnt_q;
  assign bus.stall_id     = stall_id_c;

endmodule

// File: tb/tb_rd_pipe_tracker.sv
// Bench for rd_pipe_tracker: directed scenarios with literal expectations,
// then random traffic checked every cycle against a slot-array model.
module tb_rd_pipe_tracker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rd_pipe_tracker_if #(.REG_W(7), .CNT_W(16)) bus  ();
  rd_pipe_tracker_if #(.REG_W(7), .CNT_W(4))  sbus ();

  rd_pipe_tracker #(.REG_W(7), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  rd_pipe_tracker #(.REG_W(7), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  // Narrow-counter instance sees exactly the same traffic.
  assign sbus.id_valid   = bus.id_valid;
  assign sbus.rs1_d      = bus.rs1_d;
  assign sbus.rs2_d      = bus.rs2_d;
  assign sbus.id_use_rs1 = bus.id_use_rs1;
  assign sbus.id_use_rs2 = bus.id_use_rs2;
  assign sbus.id_rd      = bus.id_rd;
  assign sbus.id_rd_we   = bus.id_rd_we;
  assign sbus.id_is_load = bus.id_is_load;
  assign sbus.flush_ex   = bus.flush_ex;
  assign sbus.mem_busy   = bus.mem_busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: m_rd[0..2] = EX, MEM, WB destinations; m_ld = EX holds a real load.
  int m_rd[3];
  bit m_ld;
  int m_mode;
  int m_cnt;

  task automatic check(input string name, input logic [63:0] act, input longint exp);
    n_tests++;
    if (act !== 64'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int entry_rd();
    return (bus.id_valid && bus.id_rd_we && bus.id_rd != 7'd0) ? int'(bus.id_rd) : 0;
  endfunction

  function automatic bit m_lu();
    return m_ld && (m_rd[0] != 0) && bus.id_valid &&
           ((bus.id_use_rs1 && int'(bus.rs1_d) == m_rd[0]) ||
            (bus.id_use_rs2 && int'(bus.rs2_d) == m_rd[0]));
  endfunction

  function automatic bit m_stall();
    return bus.mem_busy || (!bus.flush_ex && m_lu());
  endfunction

  function automatic int sat(input int v, input int top);
    return (v > top) ? top : v;
  endfunction

  always @(posedge clk) begin : model
    int nrd;
    bit nld;
    bit lu;
    lu  = m_lu();
    nrd = 0;
    nld = 1'b0;
    if (rst) begin
      m_rd   = '{0, 0, 0};
      m_ld   = 1'b0;
      m_mode = 0;
      m_cnt  = 0;
    end else if (bus.mem_busy) begin
      m_mode = 2;
      m_cnt++;
    end else begin
      if (bus.flush_ex) begin
        m_mode = 0;
      end else if (lu) begin
        m_mode = 1;
        m_cnt++;
      end else begin
        nrd    = entry_rd();
        nld    = bus.id_is_load && (nrd != 0);
        m_mode = 0;
      end
      m_rd[2] = m_rd[1];
      m_rd[1] = m_rd[0];
      m_rd[0] = nrd;
      m_ld    = nld;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_rd_EX",       bus.rd_EX,         m_rd[0]);
      check("cmp_rd_MEM",      bus.rd_MEM,        m_rd[1]);
      check("cmp_rd_WB",       bus.rd_WB,         m_rd[2]);
      check("cmp_ex_is_load",  bus.ex_is_load,    m_ld);
      check("cmp_mode",        bus.mode,          m_mode);
      check("cmp_stall_id",    bus.stall_id,      m_stall());
      check("cmp_cnt16",       bus.stall_cycles,  sat(m_cnt, 65535));
      check("cmp_cnt4",        sbus.stall_cycles, sat(m_cnt, 15));
      check("cmp_sat_rd_WB",   sbus.rd_WB,        m_rd[2]);
      check("cmp_sat_stall",   sbus.stall_id,     m_stall());
    end
  end

  task automatic drive(input bit v, input int rd, input bit we, input bit ld,
                       input int r1, input bit u1, input int r2, input bit u2,
                       input bit fl, input bit bz);
    bus.id_valid   = v;
    bus.id_rd      = 7'(rd);
    bus.id_rd_we   = we;
    bus.id_is_load = ld;
    bus.rs1_d      = 7'(r1);
    bus.id_use_rs1 = u1;
    bus.rs2_d      = 7'(r2);
    bus.id_use_rs2 = u2;
    bus.flush_ex   = fl;
    bus.mem_busy   = bz;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_rd_EX",  bus.rd_EX,        0);
    check("rst_rd_MEM", bus.rd_MEM,       0);
    check("rst_rd_WB",  bus.rd_WB,        0);
    check("rst_mode",   bus.mode,         0);
    check("rst_cnt",    bus.stall_cycles, 0);
    check("rst_stall",  bus.stall_id,     0);
    rst = 1'b0;

    // RUN: destinations 3, 5, 0 walk down the pipe.
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    check("run_ex3", bus.rd_EX, 3);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    check("run_ex5",  bus.rd_EX,  5);
    check("run_mem3", bus.rd_MEM, 3);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    check("run_ex0", bus.rd_EX, 0);
    check("run_wb3", bus.rd_WB, 3);

    // Load-use on rs2.
    drive(1, 4, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    check("lu_ex_load", bus.ex_is_load, 1);
    drive(1, 9, 1, 0, 1, 0, 4, 1, 0, 0);
    check("lu_stall_on", bus.stall_id, 1);
    tick();
    check("lu_stall_off", bus.stall_id,     0);
    check("lu_bubble",    bus.rd_EX,        0);
    check("lu_mem4",      bus.rd_MEM,       4);
    check("lu_mode",      bus.mode,         1);
    check("lu_cnt",       bus.stall_cycles, 1);
    tick();
    check("lu_resume_ex", bus.rd_EX, 9);
    check("lu_resume_md", bus.mode,  0);

    // No stall: load to x0, then source index matches but is unused.
    drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 1, 0, 0, 1, 0, 1, 0, 0);
    check("x0_no_stall", bus.stall_id, 0);
    tick();
    drive(1, 6, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 2, 1, 0, 6, 0, 1, 1, 0, 0);
    check("unused_no_stall", bus.stall_id, 0);
    tick();

    // Freeze with 7/6/5 in EX/MEM/WB.
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_stall", bus.stall_id, 1);
    end
    check("frz_ex7",  bus.rd_EX,        7);
    check("frz_mem6", bus.rd_MEM,       6);
    check("frz_wb5",  bus.rd_WB,        5);
    check("frz_mode", bus.mode,         2);
    check("frz_cnt",  bus.stall_cycles, 4);
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    check("frz_release", bus.stall_id, 0);
    tick();
    check("frz_shift_ex", bus.rd_EX,  8);
    check("frz_shift_wb", bus.rd_WB,  6);

    // Flush wins over load-use; freeze wins over flush.
    drive(1, 10, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 12, 1, 0, 10, 1, 0, 0, 1, 0);
    check("fl_no_stall", bus.stall_id, 0);
    tick();
    check("fl_bubble", bus.rd_EX,  0);
    check("fl_mem10",  bus.rd_MEM, 10);
    check("fl_mode",   bus.mode,   0);
    drive(1, 11, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 12, 1, 0, 11, 1, 0, 0, 1, 1);
    check("flfrz_stall", bus.stall_id, 1);
    tick();
    check("flfrz_ex11", bus.rd_EX,        11);
    check("flfrz_mem0", bus.rd_MEM,       0);
    check("flfrz_wb10", bus.rd_WB,        10);
    check("flfrz_cnt",  bus.stall_cycles, 5);
    drive(1, 12, 1, 0, 11, 1, 0, 0, 1, 0);
    check("flfrz_drop", bus.stall_id, 0);
    tick();
    check("flfrz_bub",  bus.rd_EX,  0);
    check("flfrz_m11",  bus.rd_MEM, 11);

    // Saturation of the 4-bit counter, then reset mid-freeze.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (20) tick();
    check("sat_cnt4",  sbus.stall_cycles, 15);
    check("sat_cnt16", bus.stall_cycles,  25);
    rst = 1'b1;
    tick();
    check("rstfrz_ex",   bus.rd_EX,         0);
    check("rstfrz_mem",  bus.rd_MEM,        0);
    check("rstfrz_wb",   bus.rd_WB,         0);
    check("rstfrz_ld",   bus.ex_is_load,    0);
    check("rstfrz_mode", bus.mode,          0);
    check("rstfrz_cnt",  bus.stall_cycles,  0);
    check("rstfrz_cnt4", sbus.stall_cycles, 0);
    rst = 1'b0;
    idle();
    tick();

    // Random traffic on a small register range to provoke frequent hits.
    repeat (3000) begin
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 99) < 80,
            $urandom_range(0, 99) < 40, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
